// File: rtl/aes_pkg.sv
// Shared AES helpers for the round tail datapath.
//   STATE_W / BYTE_W : state and byte widths
//   AES_POLY         : reduction constant of the GF(2^8) polynomial
//   xtime()          : multiply a byte by 2 in GF(2^8)
//   byte_lsb()       : bit position of the LSB of state byte i (byte 0 is the MSB byte)
package aes_pkg;

  localparam int          STATE_W  = 128;
  localparam int          BYTE_W   = 8;
  localparam logic [7:0]  AES_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic int byte_lsb(input int i);
    return STATE_W - BYTE_W * (i + 1);
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// MixColumns applied to one 32-bit column.
//   col_i : column bytes a0..a3, a0 in bits [31:24]
//   col_o : column bytes b0..b3, b0 in bits [31:24]
module mix_single_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a = 2a ^ a
  assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/round_tail_stage.sv
// AES-128 round tail: ShiftRows, MixColumns (bypassed on the last round) and
// AddRoundKey, registered into a valid/ready output with a 2-entry skid buffer.
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready             : upstream handshake
//   state_in, round_key           : SubBytes output and round key of the beat
//   last_round                    : 1 skips MixColumns
//   tag_in / tag_out              : sideband round tag, carried unchanged
//   out_valid/out_ready/state_out : downstream handshake and result
module round_tail_stage
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [STATE_W-1:0] round_key,
  input  logic               last_round,
  input  logic [TAG_W-1:0]   tag_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic [TAG_W-1:0]   tag_out
);

  logic [STATE_W-1:0] shifted;
  logic [STATE_W-1:0] mixed;
  logic [STATE_W-1:0] result;

  // ShiftRows: row r of column c takes row r of column (c+r) mod 4
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[byte_lsb(r + 4*c) +: BYTE_W] =
        state_in[byte_lsb(r + 4*((c + r) % 4)) +: BYTE_W];
    end

    mix_single_column u_mix (
      .col_i (shifted[STATE_W-1-32*c -: 32]),
      .col_o (mixed[STATE_W-1-32*c -: 32])
    );
  end

  assign result = (last_round ? shifted : mixed) ^ round_key;

  logic               m_valid_q, m_valid_d;
  logic [STATE_W-1:0] m_state_q, m_state_d;
  logic [TAG_W-1:0]   m_tag_q,   m_tag_d;
  logic               s_valid_q, s_valid_d;
  logic [STATE_W-1:0] s_state_q, s_state_d;
  logic [TAG_W-1:0]   s_tag_q,   s_tag_d;

  logic accept;
  logic drain;

  assign in_ready  = !s_valid_q;
  assign accept    = in_valid && in_ready;
  assign drain     = m_valid_q && out_ready;

  assign out_valid = m_valid_q;
  assign state_out = m_state_q;
  assign tag_out   = m_tag_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_state_d = m_state_q;
    m_tag_d   = m_tag_q;
    s_valid_d = s_valid_q;
    s_state_d = s_state_q;
    s_tag_d   = s_tag_q;

    if (drain && s_valid_q) begin
      // Skid entry is older, so it moves up; a new beat would refill S.
      m_valid_d = 1'b1;
      m_state_d = s_state_q;
      m_tag_d   = s_tag_q;
      s_valid_d = accept;
      if (accept) begin
        s_state_d = result;
        s_tag_d   = tag_in;
      end
    end else if (drain || !m_valid_q) begin
      // M is free this edge: pass-through or clear.
      m_valid_d = accept;
      if (accept) begin
        m_state_d = result;
        m_tag_d   = tag_in;
      end
    end else if (accept) begin
      // M stalled and holding: park the beat in S.
      s_valid_d = 1'b1;
      s_state_d = result;
      s_tag_d   = tag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_state_q <= '0;
      m_tag_q   <= '0;
      s_valid_q <= 1'b0;
      s_state_q <= '0;
      s_tag_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_state_q <= m_state_d;
      m_tag_q   <= m_tag_d;
      s_valid_q <= s_valid_d;
      s_state_q <= s_state_d;
      s_tag_q   <= s_tag_d;
    end
  end

endmodule

// File: tb/tb_round_tail_stage.sv
// Bench for round_tail_stage: directed FIPS-197 vectors plus a random stream
// checked through a scoreboard queue and an independent reference model.
module tb_round_tail_stage;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [127:0] round_key = '0;
  logic         last_round = 1'b0;
  logic [3:0]   tag_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;
  logic [3:0]   tag_out;

  round_tail_stage #(.TAG_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .state_in   (state_in),
    .round_key  (round_key),
    .last_round (last_round),
    .tag_in     (tag_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_out  (state_out),
    .tag_out    (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] st;
    logic [3:0]   tg;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    stalls = 0;
  bit    stream_mode = 0;
  int    stream_pops = 0;
  int    stream_gaps = 0;
  int    last_pop_cyc = 0;
  bit    held_v = 0;
  beat_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic last);
    logic [7:0]   bi[16], sr[16], mx[16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) bi[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        sr[rw + 4*c] = bi[rw + 4*((c + rw) % 4)];
    for (int c = 0; c < 4; c++) begin
      mx[4*c+0] = gmul(sr[4*c],8'd2) ^ gmul(sr[4*c+1],8'd3) ^ sr[4*c+2] ^ sr[4*c+3];
      mx[4*c+1] = sr[4*c] ^ gmul(sr[4*c+1],8'd2) ^ gmul(sr[4*c+2],8'd3) ^ sr[4*c+3];
      mx[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul(sr[4*c+2],8'd2) ^ gmul(sr[4*c+3],8'd3);
      mx[4*c+3] = gmul(sr[4*c],8'd3) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul(sr[4*c+3],8'd2);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (last ? sr[i] : mx[i]) ^ key[127-8*i -: 8];
    return r;
  endfunction

  // Monitor: pops on every output handshake, and checks hold-stability while stalled.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        check128("stall_valid", {127'd0, out_valid}, 128'd1);
        check128("stall_state", state_out, held.st);
        check128("stall_tag", {124'd0, tag_out}, {124'd0, held.tg});
      end
      held_v = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_beat: got %h tag %0d expected no beat", state_out, tag_out);
        end else begin
          e = sb.pop_front();
          check128("state_out", state_out, e.st);
          check128("tag_out", {124'd0, tag_out}, {124'd0, e.tg});
        end
        if (stream_mode) begin
          if (stream_pops > 0 && cyc != last_pop_cyc + 1) stream_gaps++;
          last_pop_cyc = cyc;
          stream_pops++;
        end
      end else if (out_valid) begin
        held_v = 1;
        held.st = state_out;
        held.tg = tag_out;
      end
    end
  end

  // Drive a beat from posedge+1 until it is accepted; expected value is queued on accept.
  task automatic send(input logic [127:0] st, input logic [127:0] key, input logic last,
                      input logic [3:0] tg, input logic [127:0] exp);
    int n;
    beat_t e;
    in_valid = 1'b1; state_in = st; round_key = key; last_round = last; tag_in = tg;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.st = exp; e.tg = tg;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected acceptance", n);
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); #1; n++; end
    check128("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  localparam logic [127:0] V1_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] V2_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] V2_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V2_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

  bit rand_done = 0;

  initial begin
    logic [127:0] st, key;
    logic         lr;

    #2;
    check128("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check128("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check128("rst_state_out", state_out, 128'd0);
    check128("rst_tag_out", {124'd0, tag_out}, 128'd0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Round 1 and final round, one at a time
    out_ready = 1'b1;
    send(V1_IN, V1_KEY, 1'b0, 4'd1, V1_OUT);
    check128("latency_valid", {127'd0, out_valid}, 128'd1);
    idle(2);
    send(V2_IN, V2_KEY, 1'b1, 4'hA, V2_OUT);
    check128("last_valid", {127'd0, out_valid}, 128'd1);
    idle(2);

    // Back-pressure: both beats stall, fill M and S
    out_ready = 1'b0;
    send(V1_IN, V1_KEY, 1'b0, 4'd1, V1_OUT);
    send(V2_IN, V2_KEY, 1'b1, 4'hA, V2_OUT);
    @(negedge clk);
    check128("bp_full_ready", {127'd0, in_ready}, 128'd0);
    check128("bp_hold_state", state_out, V1_OUT);
    idle(4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check128("bp_ready_back", {127'd0, in_ready}, 128'd1);
    check128("bp_second", state_out, V2_OUT);
    wait_empty();
    idle(1);

    // Streaming: 8 beats back-to-back, out_ready held
    stream_pops = 0; stream_gaps = 0; stalls = 0;
    stream_mode = 1;
    for (int i = 0; i < 8; i++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      send(st, key, 1'b0, 4'(i), ref_round(st, key, 1'b0));
    end
    wait_empty();
    stream_mode = 0;
    check128("stream_pops", 128'(stream_pops), 128'd8);
    check128("stream_gaps", 128'(stream_gaps), 128'd0);
    check128("stream_stalls", 128'(stalls), 128'd0);

    // Random out_ready, 1000 beats against the reference model
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          st  = {$urandom, $urandom, $urandom, $urandom};
          key = {$urandom, $urandom, $urandom, $urandom};
          lr  = 1'($urandom_range(0, 1));
          send(st, key, lr, 4'($urandom_range(0, 15)), ref_round(st, key, lr));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();

    // Reset with M and S full
    out_ready = 1'b0;
    send(V1_IN, V1_KEY, 1'b0, 4'd3, V1_OUT);
    send(V2_IN, V2_KEY, 1'b1, 4'd4, V2_OUT);
    @(negedge clk);
    check128("pre_rst_full", {127'd0, in_ready}, 128'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check128("arst_out_valid", {127'd0, out_valid}, 128'd0);
    check128("arst_in_ready", {127'd0, in_ready}, 128'd1);
    check128("arst_state_out", state_out, 128'd0);
    sb.delete();
    in_valid = 1'b1;
    idle(2);
    in_valid = 1'b0;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check128("post_rst_quiet", {127'd0, out_valid}, 128'd0);
    end
    @(posedge clk); #1;
    send(V1_IN, V1_KEY, 1'b0, 4'd1, V1_OUT);
    wait_empty();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/round_tail_stage.md
Name: round_tail_stage

Overview:
- Registered AES-128 encryption round tail that sits directly downstream of sub_bytes.
- Takes the SubBytes-processed state and applies ShiftRows, MixColumns (skipped on the final round) and AddRoundKey.
- Delivers the result through a valid/ready output with a 2-entry skid buffer.
- The round controller drives the round key and the last-round flag alongside each state.

Parameters:
- TAG_W, 4, width of the sideband round tag carried alongside each state.

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous, active-low reset.
- in_valid  in  1  Input beat present.
- in_ready  out  1  Stage can accept a beat this cycle.
- state_in  in  128  SubBytes output state.
- round_key  in  128  Round key for this beat.
- last_round  in  1  1 = final round, so MixColumns is bypassed.
- tag_in  in  TAG_W  Round index, passed through unchanged.
- out_valid  out  1  Output beat present.
- out_ready  in  1  Downstream accepts the output beat.
- state_out  out  128  Result state.
- tag_out  out  TAG_W  Tag of the beat on state_out.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset is asynchronous and active-low, on rst_n.
- Byte order: byte i = state[127-8i -: 8], i = 0..15. Row = i mod 4, column = i div 4 (FIPS-197 column-major).
- ShiftRows: out[row r, col c] = in[row r, col (c+r) mod 4].
- MixColumns, per column (a0..a3):
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Field multiply: 2x = {x[6:0],0} ^ (x[7] ? 8'h1B : 0). 3x = 2x ^ x.
- AddRoundKey: result = (last_round ? shifted : mixed) ^ round_key.
- All arithmetic is in GF(2^8); no carries. The datapath is combinational up to the output register.
- Accept condition: in_valid && in_ready. Latency is 1 cycle from acceptance to out_valid. Throughput is 1 beat/cycle while out_ready = 1.
- Storage: main register M (drives state_out, tag_out, out_valid) and skid register S.
  - in_ready = !S.valid (registered).
- On accept:
  - If !M.valid or (out_ready && M.valid), load the result into M.
  - Otherwise load the result into S.
- On M drain (out_valid && out_ready):
  - If S.valid, move S to M; S becomes invalid; a beat accepted in the same cycle goes to S.
  - Otherwise M takes the accepted beat, or clears valid if nothing was accepted.
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- While out_valid = 1 and out_ready = 0, state_out and tag_out hold stable.
- Full condition: M and S both valid gives in_ready = 0. in_ready returns to 1 the cycle after the first drain.
- Simultaneous accept and drain with S empty: M is replaced in the same edge (pass-through).
- Reset values: out_valid = 0, state_out = 0, tag_out = 0, in_ready = 1, S invalid with data 0.
- Reset asserted mid-operation discards all held beats immediately. in_valid is ignored while rst_n = 0.
- in_valid is not required to be held; the upstream may drop it when in_ready = 0 (no acceptance occurs).

Decomposition:
- Shared package aes_pkg:
  - Function xtime(byte).
  - Constant AES_POLY = 8'h1B.
  - Constants STATE_W = 128 and BYTE_W = 8.
  - Byte-index helper function.
- One combinational sub-module, mix_single_column (32-bit column in, 32-bit out), instantiated 4 times.
- ShiftRows is pure wiring inside round_tail_stage.

Test Plan:
- Round 1, last_round = 0, tag 1:
  - state_in d42711aee0bf98f1b8b45de51e415230, round_key a0fafe1788542cb123a339392a6c7605.
  - Required: state_out a49c7ff2689f352b6b5bea43026a5049 and tag_out 1, one cycle after acceptance.
- Final round, last_round = 1:
  - state_in e9098972cb31075f3d327d94af2e2cb5, round_key d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: state_out 3925841d02dc09fbdc118597196a0b32.
- Back-pressure:
  - Stimulus: stream the round-1 and final-round beats back-to-back with out_ready = 0.
  - Required: in_ready falls after 2 accepts. state_out holds a49c7ff2… stable.
  - Required: raising out_ready delivers both beats in order on consecutive cycles, then in_ready = 1.
- Streaming: 8 beats with tags 0..7, in_valid and out_ready held at 1.
  - Required: out_valid continuous from cycle 1, tags 0..7 in order, in_ready never 0.
- Random out_ready (50%), 1000 beats, checked against a reference model.
  - Required: no loss, no duplication, order preserved, outputs stable while stalled.
- Reset mid-operation: assert rst_n = 0 with M and S both full.
  - Required: out_valid = 0 and in_ready = 1 immediately (asynchronous). No stale beat appears after release.
